// File: rtl/beam_das_if.sv
// beam_das_if: frame input, configuration and result ports of beam_das_core.
interface beam_das_if #(
    parameter int NUM_CH = 8,
    parameter int IN_W   = 19,
    parameter int DEPTH  = 32,
    parameter int OUT_W  = 24
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_CH);
    localparam int DW = AW > NUM_CH ? AW : NUM_CH;
    logic                   in_valid;
    logic [NUM_CH*IN_W-1:0] pcm_in;
    logic                   cfg_we;
    logic                   cfg_ready;
    logic [CW:0]            cfg_sel;
    logic [DW-1:0]          cfg_data;
    logic [CW:0]            shift;
    logic                   out_valid;
    logic [OUT_W-1:0]       out_data;
    logic                   out_ready;
    logic                   overrun;
    logic                   ovr_clr;
    modport master (
        output in_valid, pcm_in, cfg_we, cfg_sel, cfg_data, shift, out_ready, ovr_clr,
        input  cfg_ready, out_valid, out_data, overrun
    );
    modport slave (
        input  in_valid, pcm_in, cfg_we, cfg_sel, cfg_data, shift, out_ready, ovr_clr,
        output cfg_ready, out_valid, out_data, overrun
    );
endinterface

// File: rtl/beam_das_core.sv
// beam_das_core: delay-and-sum beamformer with per-channel circular delay buffers,
// one-channel-per-cycle accumulation, gain shift and output saturation.
module beam_das_core #(
    parameter int NUM_CH = 8,
    parameter int IN_W   = 19,
    parameter int DEPTH  = 32,
    parameter int OUT_W  = 24
) (
    input logic       clk,
    input logic       rst,
    beam_das_if.slave bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(NUM_CH);
    localparam int ACC_W = IN_W + CW;
    localparam int SW    = ACC_W > OUT_W ? ACC_W : OUT_W;
    localparam logic [CW:0]   MASK_SEL = (CW+1)'(NUM_CH);
    localparam logic [CW-1:0] LAST     = CW'(NUM_CH - 1);
    localparam logic signed [SW-1:0] HI = $signed({{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
    localparam logic signed [SW-1:0] LO = ~HI;
    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
    state_t                   state;
    logic [IN_W-1:0]          mem [NUM_CH][DEPTH];
    logic [AW-1:0]            delay [NUM_CH];
    logic [NUM_CH-1:0]        mask;
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_addr;
    logic [AW:0]              fill;
    logic [CW-1:0]            ch;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic signed [SW-1:0]     sum_x;
    logic signed [SW-1:0]     shd;
    logic [IN_W-1:0]          sample;
    logic [OUT_W-1:0]         sat;
    logic                     accept;
    logic                     drop;
    logic                     hit;
    always_comb begin
        accept  = bus.in_valid && (state == IDLE || (state == OUT && bus.out_ready));
        drop    = bus.in_valid && !accept;
        rd_addr = wr_ptr - delay[ch];
        sample  = mem[ch][rd_addr];
        // fill holds frames written before the current one, so a delay equal to it still hits
        hit     = mask[ch] && ({1'b0, delay[ch]} <= fill);
        sum     = acc + (hit ? {{CW{sample[IN_W-1]}}, sample} : '0);
        sum_x   = SW'(sum);
        shd     = sum_x >>> bus.shift;
        sat     = shd > HI ? HI[OUT_W-1:0] : shd < LO ? LO[OUT_W-1:0] : shd[OUT_W-1:0];
    end
    always_ff @(posedge clk)
        if (accept)
            for (int c = 0; c < NUM_CH; c++)
                mem[c][wr_ptr] <= bus.pcm_in[c*IN_W +: IN_W];
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.cfg_ready <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.overrun   <= 1'b0;
            wr_ptr        <= '0;
            fill          <= '0;
            mask          <= '1;
            acc           <= '0;
            ch            <= '0;
            for (int c = 0; c < NUM_CH; c++)
                delay[c] <= '0;
        end else begin
            bus.overrun <= drop || (bus.overrun && !bus.ovr_clr);
            if (bus.cfg_we && bus.cfg_ready) begin
                if (bus.cfg_sel == MASK_SEL)
                    mask <= bus.cfg_data[NUM_CH-1:0];
                else if (bus.cfg_sel < MASK_SEL)
                    delay[bus.cfg_sel[CW-1:0]] <= |(bus.cfg_data >> AW) ? '1 : bus.cfg_data[AW-1:0];
            end
            if (accept) begin
                state         <= ACCUM;
                bus.cfg_ready <= 1'b0;
                bus.out_valid <= 1'b0;
                acc           <= '0;
                ch            <= '0;
            end else if (state == ACCUM) begin
                acc <= sum;
                ch  <= ch + 1'b1;
                if (ch == LAST) begin
                    state         <= OUT;
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= sat;
                    wr_ptr        <= wr_ptr + 1'b1;
                    if (!fill[AW])
                        fill <= fill + 1'b1;
                end
            end else if (state == OUT && bus.out_ready) begin
                state         <= IDLE;
                bus.cfg_ready <= 1'b1;
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_beam_das_core.sv
// tb_beam_das_core: randomized and directed checks of beam_das_core against a
// frame-history model, on a 24-bit and an 18-bit output instance sharing stimulus.
module tb_beam_das_core;
    localparam int NUM_CH = 8;
    localparam int IN_W   = 19;
    localparam int DEPTH  = 32;
    typedef int frame_t [NUM_CH];
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    beam_das_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .DEPTH(DEPTH), .OUT_W(24)) bus ();
    beam_das_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .DEPTH(DEPTH), .OUT_W(18)) bus18 ();
    beam_das_core #(.NUM_CH(NUM_CH), .IN_W(IN_W), .DEPTH(DEPTH), .OUT_W(24)) dut (.clk(clk), .rst(rst), .bus(bus));
    beam_das_core #(.NUM_CH(NUM_CH), .IN_W(IN_W), .DEPTH(DEPTH), .OUT_W(18)) dut18 (.clk(clk), .rst(rst), .bus(bus18));
    assign bus18.in_valid  = bus.in_valid;
    assign bus18.pcm_in    = bus.pcm_in;
    assign bus18.cfg_we    = bus.cfg_we;
    assign bus18.cfg_sel   = bus.cfg_sel;
    assign bus18.cfg_data  = bus.cfg_data;
    assign bus18.shift     = bus.shift;
    assign bus18.out_ready = bus.out_ready;
    assign bus18.ovr_clr   = bus.ovr_clr;
    // model: every accepted frame since reset, plus the configuration it sees
    frame_t hist[$];
    int m_delay [NUM_CH];
    int m_mask, m_shift;
    int nvec, nerr, cyc, t_acc;
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask
    function automatic int sat(input int v, input int w);
        int lim = 1 << (w - 1);
        return v > lim - 1 ? lim - 1 : v < -lim ? -lim : v;
    endfunction
    task automatic expect_next(input frame_t f, output int e24, output int e18);
        int n = hist.size();
        int s = 0;
        hist.push_back(f);
        for (int c = 0; c < NUM_CH; c++)
            if (((m_mask >> c) & 1) != 0 && m_delay[c] <= n)
                s += hist[n - m_delay[c]][c];
        e24 = sat(s >>> m_shift, 24);
        e18 = sat(s >>> m_shift, 18);
    endtask
    task automatic rnd_frame(output frame_t f);
        for (int c = 0; c < NUM_CH; c++)
            f[c] = int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
    endtask
    task automatic fill_frame(input int v, output frame_t f);
        for (int c = 0; c < NUM_CH; c++) f[c] = v;
    endtask
    task automatic model_reset();
        hist.delete();
        for (int c = 0; c < NUM_CH; c++) m_delay[c] = 0;
        m_mask = (1 << NUM_CH) - 1;
    endtask
    task automatic set_shift(input int s);
        bus.shift = 4'(s);
        m_shift = s;
    endtask
    task automatic do_reset();
        bus.in_valid = 0; bus.cfg_we = 0; bus.ovr_clr = 0; bus.out_ready = 1;
        bus.cfg_sel = '0; bus.cfg_data = '0; bus.pcm_in = '0;
        set_shift(0);
        rst = 1;
        repeat (3) tick();
        rst = 0;
        model_reset();
    endtask
    task automatic drive_pcm(input frame_t f);
        for (int c = 0; c < NUM_CH; c++) bus.pcm_in[c*IN_W +: IN_W] = f[c][IN_W-1:0];
    endtask
    task automatic start_frame(input frame_t f);
        drive_pcm(f);
        bus.in_valid = 1;
        t_acc = cyc;
        tick();
        bus.in_valid = 0;
    endtask
    task automatic wait_out(output int lat);
        for (int i = 0; i < 30 && !bus.out_valid; i++) tick();
        lat = bus.out_valid ? cyc - t_acc : -1;
    endtask
    task automatic run_frame(input frame_t f, output int lat, output logic [23:0] d24, output logic [17:0] d18);
        start_frame(f);
        wait_out(lat);
        d24 = bus.out_data;
        d18 = bus18.out_data;
    endtask
    task automatic cfg_write(input int sel, input int data);
        for (int i = 0; i < 20 && !bus.cfg_ready; i++) tick();
        nvec++;
        if (bus.cfg_ready !== 1'b1) begin nerr++; $display("FAIL cfg_ready_wait: got %b required 1", bus.cfg_ready); end
        bus.cfg_sel = 4'(sel); bus.cfg_data = 8'(data); bus.cfg_we = 1;
        tick();
        bus.cfg_we = 0;
        if (sel < NUM_CH) m_delay[sel] = data > DEPTH - 1 ? DEPTH - 1 : data;
        else if (sel == NUM_CH) m_mask = data & ((1 << NUM_CH) - 1);
    endtask
    task automatic test_reset();
        do_reset();
        nvec++; if (bus.cfg_ready !== 1'b1) begin nerr++; $display("FAIL reset_cfg_ready: got %b required 1", bus.cfg_ready); end
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        nvec++; if (bus.out_data !== 24'd0) begin nerr++; $display("FAIL reset_out_data: got %h required 0", bus.out_data); end
        nvec++; if (bus.overrun !== 1'b0) begin nerr++; $display("FAIL reset_overrun: got %b required 0", bus.overrun); end
    endtask
    task automatic test_basic();
        frame_t f; int e24, e18, lat; logic [23:0] d24; logic [17:0] d18;
        do_reset();
        fill_frame(100, f);
        expect_next(f, e24, e18);
        run_frame(f, lat, d24, d18);
        nvec++; if (lat !== NUM_CH + 1) begin nerr++; $display("FAIL basic_latency: got %0d required %0d", lat, NUM_CH + 1); end
        nvec++; if (d24 !== 24'(e24)) begin nerr++; $display("FAIL basic_sum: got %0d required %0d", $signed(d24), e24); end
        tick();
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL basic_one_cycle: out_valid %b required 0", bus.out_valid); end
        set_shift(3);
        expect_next(f, e24, e18);
        run_frame(f, lat, d24, d18);
        nvec++; if (d24 !== 24'(e24)) begin nerr++; $display("FAIL basic_shift3: got %0d required %0d", $signed(d24), e24); end
        set_shift(0);
    endtask
    task automatic test_delay();
        frame_t f; int e24, e18, lat; logic [23:0] d24; logic [17:0] d18;
        do_reset();
        cfg_write(0, 3);
        for (int k = 0; k < 6; k++) begin
            fill_frame(0, f);
            if (k == 0) f[0] = 1000;
            expect_next(f, e24, e18);
            run_frame(f, lat, d24, d18);
            nvec++; if (d24 !== 24'(e24)) begin nerr++; $display("FAIL delay3_frame%0d: got %0d required %0d", k, $signed(d24), e24); end
        end
    endtask
    task automatic test_sat();
        frame_t f; int e24, e18, lat; logic [23:0] d24; logic [17:0] d18;
        do_reset();
        fill_frame(262143, f);
        expect_next(f, e24, e18);
        run_frame(f, lat, d24, d18);
        nvec++; if (d18 !== 18'(e18)) begin nerr++; $display("FAIL sat_pos18: got %0d required %0d", $signed(d18), e18); end
        nvec++; if (d24 !== 24'(e24)) begin nerr++; $display("FAIL sat_pos24: got %0d required %0d", $signed(d24), e24); end
        fill_frame(-262144, f);
        expect_next(f, e24, e18);
        run_frame(f, lat, d24, d18);
        nvec++; if (d18 !== 18'(e18)) begin nerr++; $display("FAIL sat_neg18: got %0d required %0d", $signed(d18), e18); end
        nvec++; if (d24 !== 24'(e24)) begin nerr++; $display("FAIL sat_neg24: got %0d required %0d", $signed(d24), e24); end
    endtask
    task automatic test_overrun();
        frame_t a, b, c, d, e; int e24, e18, lat; logic [23:0] d24, h24; logic [17:0] d18; bit stable;
        do_reset();
        cfg_write(1, 1);
        rnd_frame(a); rnd_frame(b);
        expect_next(a, e24, e18);
        start_frame(a);
        tick(); tick();
        drive_pcm(b);
        bus.in_valid = 1;
        tick();
        bus.in_valid = 0;
        nvec++; if (bus.overrun !== 1'b1) begin nerr++; $display("FAIL ovr_accum_set: got %b required 1", bus.overrun); end
        wait_out(lat);
        nvec++; if (lat !== NUM_CH + 1) begin nerr++; $display("FAIL ovr_latency: got %0d required %0d", lat, NUM_CH + 1); end
        nvec++; if (bus.out_data !== 24'(e24)) begin nerr++; $display("FAIL ovr_result: got %0d required %0d", $signed(bus.out_data), e24); end
        tick();
        bus.ovr_clr = 1;
        tick();
        bus.ovr_clr = 0;
        nvec++; if (bus.overrun !== 1'b0) begin nerr++; $display("FAIL ovr_clear: got %b required 0", bus.overrun); end
        bus.out_ready = 0;
        rnd_frame(c);
        expect_next(c, e24, e18);
        run_frame(c, lat, d24, d18);
        nvec++; if (d24 !== 24'(e24)) begin nerr++; $display("FAIL ovr_hold_result: got %0d required %0d", $signed(d24), e24); end
        h24 = bus.out_data;
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                rnd_frame(d);
                drive_pcm(d);
                bus.in_valid = 1;
                bus.ovr_clr = 1;
            end
            tick();
            bus.in_valid = 0;
            bus.ovr_clr = 0;
            if (!bus.out_valid || bus.out_data !== h24) stable = 0;
        end
        nvec++; if (stable !== 1'b1) begin nerr++; $display("FAIL ovr_hold_stable: got %0d required 1 (data %h)", stable, bus.out_data); end
        nvec++; if (bus.overrun !== 1'b1) begin nerr++; $display("FAIL ovr_set_wins: got %b required 1", bus.overrun); end
        bus.out_ready = 1;
        tick();
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL ovr_release: out_valid %b required 0", bus.out_valid); end
        rnd_frame(e);
        expect_next(e, e24, e18);
        run_frame(e, lat, d24, d18);
        nvec++; if (d24 !== 24'(e24)) begin nerr++; $display("FAIL ovr_after_drop: got %0d required %0d", $signed(d24), e24); end
    endtask
    task automatic test_back_to_back();
        frame_t a, b, c; int e24, e18, lat; logic [23:0] d24; logic [17:0] d18;
        do_reset();
        cfg_write(2, 1);
        rnd_frame(a); rnd_frame(b); rnd_frame(c);
        expect_next(a, e24, e18);
        run_frame(a, lat, d24, d18);
        nvec++; if (d24 !== 24'(e24)) begin nerr++; $display("FAIL b2b_first: got %0d required %0d", $signed(d24), e24); end
        expect_next(b, e24, e18);
        start_frame(b);
        nvec++; if (bus.cfg_ready !== 1'b0) begin nerr++; $display("FAIL b2b_cfg_ready_low: got %b required 0", bus.cfg_ready); end
        bus.cfg_sel = 4'(NUM_CH); bus.cfg_data = 8'h00; bus.cfg_we = 1;
        tick();
        bus.cfg_we = 0;
        wait_out(lat);
        nvec++; if (lat !== NUM_CH + 1) begin nerr++; $display("FAIL b2b_latency: got %0d required %0d", lat, NUM_CH + 1); end
        nvec++; if (bus.out_data !== 24'(e24)) begin nerr++; $display("FAIL b2b_second: got %0d required %0d", $signed(bus.out_data), e24); end
        tick();
        expect_next(c, e24, e18);
        run_frame(c, lat, d24, d18);
        nvec++; if (d24 !== 24'(e24)) begin nerr++; $display("FAIL b2b_cfg_ignored: got %0d required %0d", $signed(d24), e24); end
    endtask
    task automatic test_wrap();
        frame_t f; int e24, e18, lat, req; logic [23:0] d24; logic [17:0] d18;
        do_reset();
        cfg_write(7, 31);
        cfg_write(NUM_CH, 'h80);
        for (int k = 0; k < 43; k++) begin
            if (k == 40) begin
                cfg_write(7, 10);
                cfg_write(7, 40);
            end
            fill_frame(0, f);
            f[7] = k;
            expect_next(f, e24, e18);
            run_frame(f, lat, d24, d18);
            req = k < 31 ? 0 : k - 31;
            nvec++; if (d24 !== 24'(req)) begin nerr++; $display("FAIL wrap_frame%0d: got %0d required %0d", k, $signed(d24), req); end
        end
    endtask
    task automatic test_reset_mid();
        frame_t f; int e24, e18, lat; logic [23:0] d24; logic [17:0] d18; bit seen;
        rnd_frame(f);
        start_frame(f);
        tick(); tick();
        rst = 1;
        tick();
        rst = 0;
        model_reset();
        nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL rmid_out_valid: got %b required 0", bus.out_valid); end
        nvec++; if (bus.cfg_ready !== 1'b1) begin nerr++; $display("FAIL rmid_cfg_ready: got %b required 1", bus.cfg_ready); end
        nvec++; if (bus.out_data !== 24'd0) begin nerr++; $display("FAIL rmid_out_data: got %h required 0", bus.out_data); end
        nvec++; if (bus.overrun !== 1'b0) begin nerr++; $display("FAIL rmid_overrun: got %b required 0", bus.overrun); end
        seen = 0;
        repeat (12) begin
            tick();
            if (bus.out_valid) seen = 1;
        end
        nvec++; if (seen !== 1'b0) begin nerr++; $display("FAIL rmid_no_output: got %0d required 0", seen); end
        rnd_frame(f);
        expect_next(f, e24, e18);
        run_frame(f, lat, d24, d18);
        nvec++; if (d24 !== 24'(e24)) begin nerr++; $display("FAIL rmid_defaults: got %0d required %0d", $signed(d24), e24); end
    endtask
    task automatic test_random();
        frame_t f; int e24, e18, lat; logic [23:0] d24; logic [17:0] d18;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < NUM_CH; c++) cfg_write(c, int'($urandom_range(0, 40)));
            cfg_write(NUM_CH, int'($urandom_range(0, 255)));
            cfg_write(NUM_CH + 1, int'($urandom_range(0, 255)));
            set_shift(r < 3 ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)));
            for (int k = 0; k < 15; k++) begin
                rnd_frame(f);
                expect_next(f, e24, e18);
                run_frame(f, lat, d24, d18);
                nvec++; if (d24 !== 24'(e24)) begin nerr++; $display("FAIL rand%0d_%0d_out24: got %0d required %0d", r, k, $signed(d24), e24); end
                nvec++; if (d18 !== 18'(e18)) begin nerr++; $display("FAIL rand%0d_%0d_out18: got %0d required %0d", r, k, $signed(d18), e18); end
            end
        end
    endtask
    initial begin
        nvec = 0; nerr = 0; cyc = 0; t_acc = 0;
        test_reset();
        test_basic();
        test_delay();
        test_sat();
        test_overrun();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
